// File: rtl/pid_mac_seq_if.sv
// Operand/product handshake between the PID sequencer and mult32.
// Sign-magnitude operands out, sign-magnitude product and flags back.
`timescale 1ns/1ps
interface pid_mac_seq_if;
  logic [31:0] mult_num1;
  logic [31:0] mult_num2;
  logic        mult_start;
  logic [31:0] mult_product;
  logic        mult_done;
  logic        mult_ovf;

  modport master (
    output mult_num1,
    output mult_num2,
    output mult_start,
    input  mult_product,
    input  mult_done,
    input  mult_ovf
  );

  modport slave (
    input  mult_num1,
    input  mult_num2,
    input  mult_start,
    output mult_product,
    output mult_done,
    output mult_ovf
  );
endinterface

// File: rtl/pid_mac_seq.sv
// Single-axis PID sequencer: error/integral/derivative, three
// multiplies through the shared mult32, saturating sum to out.
`timescale 1ns/1ps
module pid_mac_seq #(
  parameter logic signed [31:0] I_LIM = 32'sd1000000
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic               start,
  input  logic               clr_i,
  input  logic signed [31:0] setpoint,
  input  logic signed [31:0] meas,
  input  logic signed [31:0] kp,
  input  logic signed [31:0] ki,
  input  logic signed [31:0] kd,
  pid_mac_seq_if.master      mb,
  output logic signed [31:0] out,
  output logic               out_valid,
  output logic               busy,
  output logic               sat
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT,
    OVF,
    SUM
  } state_t;

  localparam logic signed [34:0] S_MAX = 35'sd2147483647;
  localparam logic signed [34:0] S_MIN = -35'sd2147483648;

  function automatic logic signed [31:0] sat32(
    input logic signed [34:0] x
  );
    if (x > S_MAX)
      return 32'sh7fffffff;
    else if (x < S_MIN)
      return 32'sh80000000;
    else
      return x[31:0];
  endfunction

  function automatic logic signed [34:0] sx33(
    input logic signed [32:0] x
  );
    return {{2{x[32]}}, x};
  endfunction

  function automatic logic signed [34:0] sx32(
    input logic signed [31:0] x
  );
    return {{3{x[31]}}, x};
  endfunction

  // Most negative value has no 31-bit magnitude; pin it to max.
  function automatic logic [31:0] sm(
    input logic signed [31:0] x
  );
    logic [31:0] m;
    m = x[31] ? 32'(-x) : 32'(x);
    if (x == 32'sh80000000)
      return {1'b1, 31'h7fffffff};
    return {x[31], m[30:0]};
  endfunction

  function automatic logic signed [31:0] tc(
    input logic [31:0] p
  );
    logic signed [31:0] m;
    m = $signed({1'b0, p[30:0]});
    return p[31] ? -m : m;
  endfunction

  state_t             state;
  logic [1:0]         idx;
  logic signed [31:0] integ;
  logic signed [31:0] e_prev;
  logic signed [31:0] d_q;
  logic signed [31:0] prod_q;
  logic               prod_sign;
  logic signed [34:0] acc;
  logic [31:0]        num1_q;
  logic [31:0]        num2_q;
  logic               start_q;
  logic signed [31:0] out_q;
  logic               valid_q;
  logic               busy_q;
  logic               sat_q;

  logic signed [32:0] e_w;
  logic signed [31:0] e_n;
  logic signed [32:0] i_w;
  logic signed [32:0] lim;
  logic signed [31:0] i_n;
  logic signed [32:0] d_w;
  logic signed [31:0] d_n;
  logic signed [31:0] gain_sel;
  logic signed [31:0] term_sel;
  logic signed [31:0] term_v;
  logic signed [34:0] acc_n;

  assign e_w = $signed({setpoint[31], setpoint})
             - $signed({meas[31], meas});
  assign e_n = sat32(sx33(e_w));
  assign i_w = $signed({integ[31], integ})
             + $signed({e_n[31], e_n});
  assign lim = $signed({I_LIM[31], I_LIM});
  assign d_w = $signed({e_n[31], e_n})
             - $signed({e_prev[31], e_prev});
  assign d_n = sat32(sx33(d_w));

  always_comb begin
    i_n = i_w[31:0];
    if (i_w > lim)
      i_n = I_LIM;
    else if (i_w < -lim)
      i_n = -I_LIM;
  end

  // Operands for the next term once the current one retires.
  always_comb begin
    gain_sel = kd;
    term_sel = d_q;
    if (idx == 2'd0) begin
      gain_sel = ki;
      term_sel = integ;
    end
  end

  always_comb begin
    term_v = prod_q;
    if (mb.mult_ovf)
      term_v = prod_sign ? 32'sh80000001 : 32'sh7fffffff;
  end

  assign acc_n = acc + sx32(term_v);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      integ     <= '0;
      e_prev    <= '0;
      d_q       <= '0;
      prod_q    <= '0;
      prod_sign <= 1'b0;
      acc       <= '0;
      num1_q    <= '0;
      num2_q    <= '0;
      start_q   <= 1'b0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else if (en) begin
      start_q <= 1'b0;
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (clr_i) begin
              integ  <= '0;
              e_prev <= '0;
            end
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          integ   <= i_n;
          d_q     <= d_n;
          e_prev  <= e_n;
          acc     <= '0;
          idx     <= 2'd0;
          sat_q   <= 1'b0;
          num1_q  <= sm(kp);
          num2_q  <= sm(e_n);
          start_q <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mb.mult_done) begin
            prod_q    <= tc(mb.mult_product);
            prod_sign <= mb.mult_product[31];
            state     <= OVF;
          end
        end
        OVF: begin
          acc <= acc_n;
          if (mb.mult_ovf)
            sat_q <= 1'b1;
          if (idx != 2'd2) begin
            idx     <= idx + 2'd1;
            num1_q  <= sm(gain_sel);
            num2_q  <= sm(term_sel);
            start_q <= 1'b1;
            state   <= ISSUE;
          end else begin
            state <= SUM;
          end
        end
        SUM: begin
          out_q   <= sat32(acc);
          valid_q <= 1'b1;
          if (acc > S_MAX || acc < S_MIN)
            sat_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mb.mult_num1  = num1_q;
  assign mb.mult_num2  = num2_q;
  assign mb.mult_start = start_q & en;
  assign out           = out_q;
  assign out_valid     = valid_q & en;
  assign busy          = busy_q;
  assign sat           = sat_q;

endmodule

// File: tb/tb_pid_mac_seq.sv
// Directed bench for pid_mac_seq with a behavioural mult32
// (done 32 cycles after start, overflow flag one cycle later).
`timescale 1ns/1ps
module tb_pid_mac_seq;

  logic               clk = 1'b0;
  logic               nrst;
  logic               en;
  logic               start;
  logic               clr_i;
  logic signed [31:0] setpoint;
  logic signed [31:0] meas;
  logic signed [31:0] kp;
  logic signed [31:0] ki;
  logic signed [31:0] kd;
  logic signed [31:0] out;
  logic               out_valid;
  logic               busy;
  logic               sat;

  int n_chk  = 0;
  int n_fail = 0;

  pid_mac_seq_if mb ();

  pid_mac_seq #(.I_LIM(32'sd100)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .start     (start),
    .clr_i     (clr_i),
    .setpoint  (setpoint),
    .meas      (meas),
    .kp        (kp),
    .ki        (ki),
    .kd        (kd),
    .mb        (mb),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [5:0]  m_cnt;
  logic        m_ovf_pend;
  int          ovf_cnt;
  logic [61:0] m_mag;

  assign m_mag = m_a[30:0] * m_b[30:0];

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_a             <= '0;
      m_b             <= '0;
      m_cnt           <= '0;
      m_ovf_pend      <= 1'b0;
      ovf_cnt         <= 0;
      mb.mult_done    <= 1'b0;
      mb.mult_product <= '0;
      mb.mult_ovf     <= 1'b0;
    end else if (en) begin
      mb.mult_done <= 1'b0;
      if (mb.mult_done) begin
        mb.mult_ovf <= m_ovf_pend;
        if (m_ovf_pend)
          ovf_cnt <= ovf_cnt + 1;
      end
      if (mb.mult_start) begin
        m_a         <= mb.mult_num1;
        m_b         <= mb.mult_num2;
        m_cnt       <= 6'd31;
        mb.mult_ovf <= 1'b0;
      end else if (m_cnt == 6'd1) begin
        mb.mult_done    <= 1'b1;
        mb.mult_product <= {m_a[31] ^ m_b[31], m_mag[30:0]};
        m_ovf_pend      <= |m_mag[61:31];
        m_cnt           <= '0;
      end else if (m_cnt != 6'd0) begin
        m_cnt <= m_cnt - 6'd1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_eval(input  logic        clr,
                          output int          lat,
                          output logic [31:0] n1,
                          output logic [31:0] n2,
                          output logic        bz_ok);
    logic got_op;
    got_op = 1'b0;
    bz_ok  = 1'b1;
    n1     = '0;
    n2     = '0;
    @(negedge clk);
    start = 1'b1;
    clr_i = clr;
    @(posedge clk);
    #1;
    start = 1'b0;
    clr_i = 1'b0;
    lat   = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (mb.mult_start && !got_op) begin
        n1     = mb.mult_num1;
        n2     = mb.mult_num2;
        got_op = 1'b1;
      end
      if (out_valid == busy)
        bz_ok = 1'b0;
    end while (!out_valid && lat < 400);
    if (!out_valid)
      chk("timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic set_in(input logic signed [31:0] p,
                        input logic signed [31:0] i,
                        input logic signed [31:0] d,
                        input logic signed [31:0] sp,
                        input logic signed [31:0] ms);
    kp       = p;
    ki       = i;
    kd       = d;
    setpoint = sp;
    meas     = ms;
  endtask

  int          lat;
  logic [31:0] n1;
  logic [31:0] n2;
  logic        bz_ok;
  int          ovf0;
  int          extra;

  initial begin
    nrst  = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    clr_i = 1'b0;
    set_in(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_num1", mb.mult_num1, 32'd0);
    chk("rst_num2", mb.mult_num2, 32'd0);
    chk("rst_mstart", 32'(mb.mult_start), 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    set_in(2, 0, 0, 100, 40);
    run_eval(1'b0, lat, n1, n2, bz_ok);
    chk("p_out", out, 32'd120);
    chk("p_lat", 32'(lat), 32'd104);
    chk("p_sat", 32'(sat), 32'd0);
    chk("p_busy", 32'(bz_ok), 32'd1);
    chk("p_num1", n1, 32'd2);
    chk("p_num2", n2, 32'd60);

    set_in(0, 1, 0, 100, 40);
    run_eval(1'b1, lat, n1, n2, bz_ok);
    chk("i_first", out, 32'd60);
    run_eval(1'b0, lat, n1, n2, bz_ok);
    chk("i_clamp", out, 32'd100);
    run_eval(1'b0, lat, n1, n2, bz_ok);
    chk("i_hold", out, 32'd100);
    run_eval(1'b1, lat, n1, n2, bz_ok);
    chk("i_clr", out, 32'd60);

    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    set_in(0, 0, 1, 100, 40);
    run_eval(1'b0, lat, n1, n2, bz_ok);
    chk("d_first", out, 32'd60);
    run_eval(1'b0, lat, n1, n2, bz_ok);
    chk("d_second", out, 32'd0);

    set_in(3, 0, 0, 0, 5);
    run_eval(1'b0, lat, n1, n2, bz_ok);
    chk("s_num1", n1, 32'd3);
    chk("s_num2", n2, 32'h80000005);
    chk("s_out", out, 32'hfffffff1);
    chk("s_sat", 32'(sat), 32'd0);

    ovf0 = ovf_cnt;
    set_in(32'sd1048576, 0, 0, 4096, 0);
    run_eval(1'b0, lat, n1, n2, bz_ok);
    chk("o_seen", 32'(ovf_cnt - ovf0), 32'd1);
    chk("o_out", out, 32'h7fffffff);
    chk("o_sat", 32'(sat), 32'd1);
    set_in(-32'sd1048576, 0, 0, 4096, 0);
    run_eval(1'b0, lat, n1, n2, bz_ok);
    chk("on_num1", n1, 32'h80100000);
    chk("on_out", out, 32'h80000001);
    chk("on_sat", 32'(sat), 32'd1);

    set_in(2, 0, 0, 100, 40);
    run_eval(1'b0, lat, n1, n2, bz_ok);
    chk("sc_out", out, 32'd120);
    chk("sc_sat", 32'(sat), 32'd0);

    fork
      run_eval(1'b0, lat, n1, n2, bz_ok);
      begin
        repeat (51) @(posedge clk);
        #2 en = 1'b0;
        repeat (10) @(posedge clk);
        #2 en = 1'b1;
      end
    join
    chk("en_out", out, 32'd120);
    chk("en_lat", 32'(lat), 32'd114);

    fork
      run_eval(1'b0, lat, n1, n2, bz_ok);
      begin
        repeat (21) @(posedge clk);
        #2 setpoint = 32'sd7;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #2 start = 1'b0;
      end
    join
    chk("bz_out", out, 32'd120);
    chk("bz_lat", 32'(lat), 32'd104);
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (busy || out_valid)
        extra++;
    end
    chk("bz_norestart", 32'(extra), 32'd0);

    set_in(0, 1, 0, 100, 40);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("ar_out", out, 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_num2", mb.mult_num2, 32'd0);
    chk("ar_mstart", 32'(mb.mult_start), 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    run_eval(1'b0, lat, n1, n2, bz_ok);
    chk("ar_integ", out, 32'd60);
    chk("ar_lat", 32'(lat), 32'd104);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
